// File: rtl/param_bus_datapath.sv
`default_nettype none
// ============================================================================
// Module   : param_bus_datapath
// Brief    : Single-bus register-file datapath, Y/Z operand staging, HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module param_bus_datapath #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [AW-1:0]    rc,
    input  logic [WIDTH-1:0] imm,
    input  logic             ext_we,
    input  logic [AW-1:0]    ext_addr,
    input  logic [WIDTH-1:0] ext_wdata,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] bus_out
);
    localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] c_op_add  = 4'd0;
    localparam logic [3:0] c_op_sub  = 4'd1;
    localparam logic [3:0] c_op_and  = 4'd2;
    localparam logic [3:0] c_op_or   = 4'd3;
    localparam logic [3:0] c_op_shr  = 4'd4;
    localparam logic [3:0] c_op_shra = 4'd5;
    localparam logic [3:0] c_op_shl  = 4'd6;
    localparam logic [3:0] c_op_ror  = 4'd7;
    localparam logic [3:0] c_op_rol  = 4'd8;
    localparam logic [3:0] c_op_neg  = 4'd9;
    localparam logic [3:0] c_op_not  = 4'd10;
    localparam logic [3:0] c_op_mul  = 4'd11;
    localparam logic [3:0] c_op_addi = 4'd12;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [3:0]               r_op;
    logic [AW-1:0]            r_ra;
    logic [AW-1:0]            r_rb;
    logic [AW-1:0]            r_rc;
    logic [WIDTH-1:0]         r_imm;
    logic [WIDTH-1:0]         r_y;
    logic [2*WIDTH-1:0]       r_z;
    logic [WIDTH-1:0]         r_hi;
    logic [WIDTH-1:0]         r_lo;
    logic [WIDTH-1:0]         r_regs [0:NREGS-1];

    logic [WIDTH-1:0]         w_bus;
    logic [SW-1:0]            w_sh;
    logic [WIDTH-1:0]         w_lo;
    logic [2*WIDTH-1:0]       w_z;
    logic [2*WIDTH-1:0]       w_dbl;
    logic [2*WIDTH-1:0]       w_ror;
    logic [2*WIDTH-1:0]       w_rol;
    logic signed [2*WIDTH-1:0] w_prod;
    logic                     w_accept;
    logic                     w_fsm_wr;
    logic                     w_ext_wr;

    // R0 is never written, so a plain array read already returns zero for it
    function automatic logic [WIDTH-1:0] reg_rd(input logic [AW-1:0] idx,
                                               input logic [WIDTH-1:0] regs [0:NREGS-1]);
        reg_rd = (int'(idx) < NREGS) ? regs[idx] : '0;
    endfunction

    assign w_accept = (r_state == IDLE) && start;
    assign w_fsm_wr = (r_state == T3) && ((r_op < c_op_mul) || (r_op == c_op_addi))
                      && (r_ra != '0) && (int'(r_ra) < NREGS);
    assign w_ext_wr = (r_state == IDLE) && !start && ext_we
                      && (ext_addr != '0) && (int'(ext_addr) < NREGS);

    always_comb begin
        w_bus = '0;
        case (r_state)
            T1:      w_bus = reg_rd(r_rb, r_regs);
            T2:      w_bus = (r_op == c_op_addi) ? r_imm : reg_rd(r_rc, r_regs);
            T3:      w_bus = r_z[WIDTH-1:0];
            T4:      w_bus = r_z[2*WIDTH-1:WIDTH];
            default: w_bus = '0;
        endcase
    end

    assign w_sh   = w_bus[SW-1:0];
    assign w_dbl  = {r_y, r_y};
    assign w_ror  = w_dbl >> w_sh;
    assign w_rol  = w_dbl << w_sh;
    assign w_prod = $signed({{WIDTH{r_y[WIDTH-1]}}, r_y})
                  * $signed({{WIDTH{w_bus[WIDTH-1]}}, w_bus});

    always_comb begin
        w_lo = '0;
        case (r_op)
            c_op_add,
            c_op_addi: w_lo = r_y + w_bus;
            c_op_sub:  w_lo = r_y - w_bus;
            c_op_and:  w_lo = r_y & w_bus;
            c_op_or:   w_lo = r_y | w_bus;
            c_op_shr:  w_lo = r_y >> w_sh;
            c_op_shra: w_lo = $signed(r_y) >>> w_sh;
            c_op_shl:  w_lo = r_y << w_sh;
            c_op_ror:  w_lo = w_ror[WIDTH-1:0];
            c_op_rol:  w_lo = w_rol[2*WIDTH-1:WIDTH];
            c_op_neg:  w_lo = '0 - r_y;
            c_op_not:  w_lo = ~r_y;
            default:   w_lo = '0;
        endcase
    end

    // Only MUL produces a non-zero upper half
    assign w_z = (r_op == c_op_mul) ? w_prod : {{WIDTH{1'b0}}, w_lo};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? T1 : IDLE;
            T1:      w_next = T2;
            T2:      w_next = T3;
            T3:      w_next = (r_op == c_op_mul) ? T4 : DONE;
            T4:      w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_op  <= '0;
            r_ra  <= '0;
            r_rb  <= '0;
            r_rc  <= '0;
            r_imm <= '0;
            r_y   <= '0;
            r_z   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_accept) begin
                r_op  <= op;
                r_ra  <= ra;
                r_rb  <= rb;
                r_rc  <= rc;
                r_imm <= imm;
            end
            if (r_state == T1) r_y <= w_bus;
            if (r_state == T2) r_z <= w_z;
            if ((r_state == T3) && (r_op == c_op_mul)) r_lo <= w_bus;
            if (r_state == T4) r_hi <= w_bus;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_fsm_wr) begin
            r_regs[r_ra] <= w_bus;
        end else if (w_ext_wr) begin
            r_regs[ext_addr] <= ext_wdata;
        end
    end

    assign rd_data = reg_rd(rd_addr, r_regs);
    assign busy    = (r_state != IDLE);
    assign done    = (r_state == DONE);
    assign err     = (r_state == DONE) && (r_op > c_op_addi);
    assign hi_out  = r_hi;
    assign lo_out  = r_lo;
    assign bus_out = w_bus;

endmodule
`default_nettype wire

// File: tb/tb_param_bus_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_bus_datapath
// Brief    : Scoreboard bench for param_bus_datapath (WIDTH=32, NREGS=16).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_param_bus_datapath;
    localparam int W  = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic [3:0]    op;
    logic [AW-1:0] ra, rb, rc, ext_addr, rd_addr;
    logic [W-1:0]  imm, ext_wdata;
    logic          ext_we;
    logic [W-1:0]  rd_data, hi_out, lo_out, bus_out;
    logic          busy, done, err;

    param_bus_datapath #(.WIDTH(W), .NREGS(16)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op),
        .ra(ra), .rb(rb), .rc(rc), .imm(imm),
        .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err),
        .hi_out(hi_out), .lo_out(lo_out), .bus_out(bus_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          dest;
        logic [63:0] z;
        int          lat;
        logic        err;
        logic        mul;
    } exp_t;

    exp_t        sb[$];
    logic [W-1:0] m_regs [16];
    logic [W-1:0] m_hi, m_lo;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] alu_model(input logic [3:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0]        r;
        logic signed [63:0] p;
        int                 s;
        s = int'(b[4:0]);
        r = 32'h0;
        case (o)
            4'd0, 4'd12: r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a >> s;
            4'd5:  r = $signed(a) >>> s;
            4'd6:  r = a << s;
            4'd7:  r = (a >> s) | (a << (32 - s));
            4'd8:  r = (a << s) | (a >> (32 - s));
            4'd9:  r = 32'h0 - a;
            4'd10: r = ~a;
            4'd11: begin
                p = $signed(a) * $signed(b);
                return p;
            end
            default: r = 32'h0;
        endcase
        return {32'h0, r};
    endfunction

    task automatic read_reg(input int idx, output logic [W-1:0] v);
        rd_addr = AW'(idx);
        #1;
        v = rd_data;
    endtask

    task automatic verify_regs(input string tag);
        logic [W-1:0] v;
        for (int i = 0; i < 16; i++) begin
            read_reg(i, v);
            check($sformatf("%s_r%0d", tag, i), v, m_regs[i]);
        end
        check({tag, "_hi"}, hi_out, m_hi);
        check({tag, "_lo"}, lo_out, m_lo);
    endtask

    task automatic ext_load(input int a, input logic [W-1:0] d);
        @(negedge clk);
        ext_we = 1'b1; ext_addr = AW'(a); ext_wdata = d;
        @(negedge clk);
        ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        if (a != 0) m_regs[a] = d;
    endtask

    // inject=1 pulses start and ext_we (to R9) while the operation is in T2
    task automatic run_op(input logic [3:0] o, input int a, input int b, input int c,
                          input logic [W-1:0] im, input bit inject);
        exp_t         e, g;
        logic [63:0]  z;
        logic [W-1:0] v;
        int           cnt;
        z = alu_model(o, m_regs[b], (o == 4'd12) ? im : m_regs[c]);
        e.dest = a; e.z = z; e.lat = (o == 4'd11) ? 5 : 4;
        e.err = (o > 4'd12); e.mul = (o == 4'd11);
        if (!e.err) begin
            if (e.mul) begin m_lo = z[31:0]; m_hi = z[63:32]; end
            else if (a != 0) m_regs[a] = z[31:0];
        end
        sb.push_back(e);

        @(negedge clk);
        start = 1'b1; op = o; ra = AW'(a); rb = AW'(b); rc = AW'(c); imm = im;
        @(negedge clk);
        start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0; imm = '0;
        cnt = 1;
        while (!done && cnt < 12) begin
            @(negedge clk);
            cnt++;
            if (inject && cnt == 2) begin
                start = 1'b1; op = 4'd0; ra = 4'd9; rb = 4'd1; rc = 4'd2;
                ext_we = 1'b1; ext_addr = 4'd9; ext_wdata = 32'h55;
            end else if (inject && cnt == 3) begin
                start = 1'b0; ra = '0; rb = '0; rc = '0;
                ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
            end
        end
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            g = sb.pop_front();
            if (!done) check("done_timeout", 0, 1);
            check($sformatf("latency_op%0d", o), cnt, g.lat);
            check($sformatf("err_op%0d", o), err, g.err);
            check("bus_in_done", bus_out, 0);
            check("busy_in_done", busy, 1);
            if (g.mul) begin
                check("mul_lo", lo_out, g.z[31:0]);
                check("mul_hi", hi_out, g.z[63:32]);
            end else begin
                read_reg(g.dest, v);
                check($sformatf("dest_op%0d_r%0d", o, g.dest), v, m_regs[g.dest]);
            end
        end
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_err", err, 0);
        check("idle_bus", bus_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] v;
        clr = 1'b0; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0; imm = '0;
        ext_we = 1'b0; ext_addr = '0; ext_wdata = '0; rd_addr = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_hi = '0; m_lo = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_bus", bus_out, 0);
        verify_regs("rst");
        @(posedge clk); #1 clr = 1'b1;

        // basic ADD
        ext_load(1, 32'd5); ext_load(2, 32'd7);
        run_op(4'd0, 3, 1, 2, '0, 1'b0);
        read_reg(3, v); check("add_r3_const", v, 32'd12);

        // wrap and SUB
        ext_load(1, 32'hFFFF_FFFF); ext_load(2, 32'd1);
        run_op(4'd0, 4, 1, 2, '0, 1'b0);
        read_reg(4, v); check("add_wrap_r4", v, 32'd0);
        run_op(4'd1, 5, 2, 1, '0, 1'b0);
        read_reg(5, v); check("sub_r5", v, 32'd2);

        // signed MUL
        ext_load(1, 32'hFFFF_FFFD); ext_load(2, 32'd4);
        run_op(4'd11, 7, 1, 2, '0, 1'b0);
        check("mul_lo_const", lo_out, 32'hFFFF_FFF4);
        check("mul_hi_const", hi_out, 32'hFFFF_FFFF);
        verify_regs("after_mul");

        // ROL and R0 protection
        ext_load(1, 32'h8000_0001); ext_load(2, 32'd1);
        run_op(4'd8, 6, 1, 2, '0, 1'b0);
        read_reg(6, v); check("rol_r6", v, 32'h3);
        run_op(4'd12, 0, 0, 0, 32'd9, 1'b0);
        read_reg(0, v); check("addi_r0", v, 32'd0);
        ext_load(0, 32'hDEAD_BEEF);
        read_reg(0, v); check("ext_r0", v, 32'd0);

        // illegal opcode and injected start/ext_we while busy
        run_op(4'd14, 11, 1, 2, '0, 1'b0);
        verify_regs("after_illegal");
        run_op(4'd0, 8, 1, 2, '0, 1'b1);
        verify_regs("after_inject");

        // sweep the remaining ops with random operands
        for (int i = 0; i <= 12; i++) begin
            ext_load(1, $urandom);
            ext_load(2, (i % 2 == 0) ? W'($urandom_range(0, 40)) : $urandom);
            run_op(4'(i), 3 + (i % 12), 1, 2, $urandom, 1'b0);
        end
        run_op(4'd13, 12, 1, 2, '0, 1'b0);
        run_op(4'd15, 13, 1, 2, '0, 1'b0);
        verify_regs("after_sweep");

        // abort in T2
        ext_load(1, 32'd5); ext_load(2, 32'd7);
        @(negedge clk);
        start = 1'b1; op = 4'd0; ra = 4'd10; rb = 4'd1; rc = 4'd2;
        @(negedge clk);
        start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
        @(negedge clk);
        check("abort_busy_t2", busy, 1);
        clr = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bus", bus_out, 0);
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        m_hi = '0; m_lo = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_nodone", done, 0);
        end
        verify_regs("abort");
        @(posedge clk); #1 clr = 1'b1;
        run_op(4'd12, 10, 0, 0, 32'd77, 1'b0);
        read_reg(10, v); check("post_reset_addi", v, 32'd77);
        ext_load(1, 32'd5); ext_load(2, 32'd7);
        run_op(4'd0, 10, 1, 2, '0, 1'b0);
        read_reg(10, v); check("post_reset_add", v, 32'd12);
        verify_regs("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/param_bus_datapath.md
PARAM_BUS_DATAPATH -- requirements
Module: param_bus_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath and register width.
REQ-002 SHALL have parameter NREGS, default 16, number of general registers; AW = clog2(NREGS).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to execute one operation.
REQ-006 SHALL have port op  input  4  operation code.
REQ-007 SHALL have ports ra, rb, rc  input  AW each  destination, first source, second source.
REQ-008 SHALL have port imm  input  WIDTH  immediate operand for ADDI.
REQ-009 SHALL have ports ext_we (input, 1), ext_addr (input, AW), ext_wdata (input, WIDTH)  external register load.
REQ-010 SHALL have ports rd_addr (input, AW), rd_data (output, WIDTH)  combinational register readback.
REQ-011 SHALL have ports busy, done, err  output  1 each  status.
REQ-012 SHALL have ports hi_out, lo_out, bus_out  output  WIDTH each  HI, LO and current bus value.

Function
REQ-013 SHALL use the FSM states IDLE, T1, T2, T3, T4, DONE, with exactly one active state.
REQ-014 SHALL accept start only in IDLE; on accept, latch op/ra/rb/rc/imm and go to T1; start in any other state is ignored.
REQ-015 T1 SHALL drive R[rb] on the bus and load Y.
REQ-016 T2 SHALL drive R[rc] on the bus (imm for ADDI) and load the 2*WIDTH Z register with ALU(Y, bus).
REQ-017 T3 SHALL drive Zlow on the bus and write it to R[ra]; for MUL it SHALL write LO instead.
REQ-018 T4 SHALL be entered only for MUL, writing Zhigh to HI.
REQ-019 The state after T3 (T4 for MUL) SHALL be DONE; DONE SHALL return to IDLE after one cycle.
REQ-020 busy SHALL be high in T1..DONE; done SHALL be high only in DONE, a one-cycle pulse.
REQ-021 Latency from the accepting edge to done high SHALL be 4 cycles (non-MUL) or 5 cycles (MUL).
REQ-022 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR logical, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG(Y), 10 NOT(Y), 11 MUL signed, 12 ADDI.
REQ-023 Arithmetic results SHALL be modulo 2^WIDTH, and Zhigh SHALL be zero except for MUL.
REQ-024 The shift/rotate amount SHALL be the low clog2(WIDTH) bits of the bus.
REQ-025 Opcodes 13-15 SHALL run the full sequence with no register/HI/LO write and err high during DONE.
REQ-026 R0 SHALL always read zero, and writes to R0 (FSM or external) SHALL be discarded.
REQ-027 ext_we SHALL write R[ext_addr] only when in IDLE and start is low; otherwise it is dropped.
REQ-028 bus_out SHALL be zero in IDLE and DONE.
REQ-029 ra equal to rb or rc SHALL be legal, since operands are captured in Y and Z before the write.

Reset
REQ-030 While clr is low: all registers, Y, Z, HI, LO zero; state IDLE; busy, done, err low.
REQ-031 clr asserted mid-operation SHALL abort with no pending write and no done pulse.
REQ-032 After clr release, the first rising edge SHALL be able to accept start.

Verification
REQ-033 ext load R1=5, R2=7; start ADD ra=3 rb=1 rc=2 -> done 4 cycles later, R3=12, err=0.
REQ-034 R1=0xFFFFFFFF, R2=1, ADD ra=4 -> R4=0 (wrap); SUB R2-R1 into R5 -> R5=2.
REQ-035 R1=-3, R2=4, MUL -> LO=0xFFFFFFF4, HI=0xFFFFFFFF, done at 5 cycles, R registers unchanged.
REQ-036 ROL R1=0x80000001 by R2=1 into R6 -> 0x00000003; ADDI rb=0 imm=9 ra=0 -> R0 still reads 0.
REQ-037 Start with op=14 -> err pulse with done and no state change; start and ext_we pulsed while busy -> both ignored.
REQ-038 clr low during T2 of an ADD -> destination unchanged (0), no done; a start after release completes normally.
